alu_issue_ctrl: RTL

//  Execute-stage sequencer for the RV32I integer ALU. Accepts decoded R_ALU/I_ALU ops from decode

---
 rtl/rv32i_pkg.sv | 40 ++++
 rtl/alu.sv | 42 ++++
 rtl/alu_issue_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// RV32I shared types and encodings.
// Used by the execute-stage ALU and its issue controller.
package rv32i_pkg;

  typedef logic [31:0] data;
  typedef logic [6:0]  opcode_t;
  typedef logic [2:0]  funct3_t;
  typedef logic [6:0]  funct7_t;
  typedef logic [11:0] i_imm;
  typedef logic [4:0]  reg_idx;

  localparam opcode_t R_ALU = 7'b0110011;
  localparam opcode_t I_ALU = 7'b0010011;

  localparam funct3_t ADD_SUB = 3'd0;
  localparam funct3_t SLL     = 3'd1;
  localparam funct3_t SLT     = 3'd2;
  localparam funct3_t SLTU    = 3'd3;
  localparam funct3_t XOR     = 3'd4;
  localparam funct3_t SRL_SRA = 3'd5;
  localparam funct3_t OR      = 3'd6;
  localparam funct3_t AND     = 3'd7;

  localparam funct7_t FUNCT7_BASE = 7'h00;
  localparam funct7_t FUNCT7_ALT  = 7'h20;
  localparam reg_idx  REG_ZERO    = 5'd0;

  typedef struct packed {
    opcode_t opcode;
    funct3_t funct3;
    funct7_t funct7;
    i_imm    imm;
    reg_idx  rs1;
    reg_idx  rs2;
    reg_idx  rd;
    data     rs1_val;
    data     rs2_val;
  } id_ex_t;

endpackage

// File: rtl/alu.sv
// RV32I integer ALU, purely combinational.
// Legality is judged by the caller; this only computes.
module alu
  import rv32i_pkg::*;
(
  input  data     operand_1,
  input  data     operand_2,
  input  opcode_t opcode,
  input  i_imm    imm,
  input  funct3_t funct3,
  input  funct7_t funct7,
  output data     result
);

  data        op_b;
  data        sum;
  data        sra;
  logic [4:0] shamt;
  logic       alt;

  always_comb begin
    op_b   = (opcode == R_ALU) ? operand_2 : {{20{imm[11]}}, imm};
    shamt  = op_b[4:0];
    alt    = (funct7 == FUNCT7_ALT);
    sum    = (opcode == R_ALU && alt) ? operand_1 - op_b
                                      : operand_1 + op_b;
    sra    = $signed(operand_1) >>> shamt;
    result = '0;
    case (funct3)
      ADD_SUB: result = sum;
      SLL:     result = operand_1 << shamt;
      SLT:     result = {31'd0, $signed(operand_1) < $signed(op_b)};
      SLTU:    result = {31'd0, operand_1 < op_b};
      XOR:     result = operand_1 ^ op_b;
      SRL_SRA: result = alt ? sra : operand_1 >> shamt;
      OR:      result = operand_1 | op_b;
      AND:     result = operand_1 & op_b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: HOLD -> alu -> OUT, two-entry elastic.
// Forwards from OUT and write-back, flags and counts illegal ops.
module alu_issue_ctrl
  import rv32i_pkg::*;
#(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  opcode_t          in_opcode,
  input  funct3_t          in_funct3,
  input  funct7_t          in_funct7,
  input  i_imm             in_imm,
  input  reg_idx           in_rs1,
  input  reg_idx           in_rs2,
  input  reg_idx           in_rd,
  input  data              in_rs1_val,
  input  data              in_rs2_val,
  input  logic             wb_valid,
  input  reg_idx           wb_rd,
  input  data              wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output reg_idx           out_rd,
  output data              out_result,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  function automatic logic is_legal(
    opcode_t op, funct3_t f3, funct7_t f7
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      op == R_ALU:
        ok = (f7 == FUNCT7_BASE) ||
             (f7 == FUNCT7_ALT &&
              (f3 == ADD_SUB || f3 == SRL_SRA));
      op == I_ALU && f3 == SLL:
        ok = (f7 == FUNCT7_BASE);
      op == I_ALU && f3 == SRL_SRA:
        ok = (f7 == FUNCT7_BASE) || (f7 == FUNCT7_ALT);
      op == I_ALU && f3 != SLL && f3 != SRL_SRA:
        ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Youngest producer wins: OUT is newer than write-back.
  function automatic data fwd(
    reg_idx rs, data cap,
    logic o_ok, reg_idx o_rd, data o_val,
    logic w_ok, reg_idx w_rd, data w_val
  );
    data v;
    v = cap;
    if (rs == REG_ZERO) v = '0;
    else if (o_ok && o_rd == rs) v = o_val;
    else if (w_ok && w_rd == rs) v = w_val;
    return v;
  endfunction

  id_ex_t hold;
  logic   hold_valid;
  logic   advance;
  logic   accept;
  logic   legal;
  logic   out_hit;
  logic   wb_hit;
  data    op_1;
  data    op_2;
  data    alu_res;

  assign advance  = hold_valid && (!out_valid || out_ready);
  assign in_ready = rst_n && !flush && (!hold_valid || advance);
  assign accept   = in_valid && in_ready;
  assign out_hit  = FWD_EN && out_valid && !out_illegal;
  assign wb_hit   = FWD_EN && wb_valid;

  assign op_1 = fwd(hold.rs1, hold.rs1_val, out_hit, out_rd,
                    out_result, wb_hit, wb_rd, wb_data);
  assign op_2 = fwd(hold.rs2, hold.rs2_val, out_hit, out_rd,
                    out_result, wb_hit, wb_rd, wb_data);
  assign legal = is_legal(hold.opcode, hold.funct3, hold.funct7);

  alu u_alu (
    .operand_1 (op_1),
    .operand_2 (op_2),
    .opcode    (hold.opcode),
    .imm       (hold.imm),
    .funct3    (hold.funct3),
    .funct7    (hold.funct7),
    .result    (alu_res)
  );

  // Stalled ops keep re-latching operands so a one-cycle WB is not lost.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold <= '{opcode:  in_opcode,
                funct3:  in_funct3,
                funct7:  in_funct7,
                imm:     in_imm,
                rs1:     in_rs1,
                rs2:     in_rs2,
                rd:      in_rd,
                rs1_val: in_rs1_val,
                rs2_val: in_rs2_val};
    end else if (hold_valid && !advance) begin
      hold.rs1_val <= op_1;
      hold.rs2_val <= op_2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_valid  <= 1'b0;
      out_valid   <= 1'b0;
      out_rd      <= '0;
      out_result  <= '0;
      out_illegal <= 1'b0;
      illegal_cnt <= '0;
    end else if (flush) begin
      hold_valid <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (out_valid && out_ready && out_illegal &&
          illegal_cnt != '1)
        illegal_cnt <= illegal_cnt + CNT_W'(1);
      if (advance) begin
        out_valid   <= 1'b1;
        out_rd      <= hold.rd;
        out_result  <= legal ? alu_res : '0;
        out_illegal <= !legal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) hold_valid <= 1'b1;
      else if (advance) hold_valid <= 1'b0;
    end
  end

endmodule
